// File: rtl/ym3438_pg_detune_apply_if.sv
// Slot-rate bus between the detune/frequency sources and the PG detune-apply stage.
// master drives the per-slot operands and phase enables; slave returns the phase increment and slot tag.
interface ym3438_pg_detune_apply_if #(
   parameter int INC_WIDTH = 20
);
   logic                 c1;
   logic                 c2;
   logic                 sync;
   logic [10:0]          fnum;
   logic [2:0]           block;
   logic [3:0]           multi;
   logic                 dt_sign;
   logic [4:0]           dt_value;
   logic [INC_WIDTH-1:0] pg_inc;
   logic [4:0]           slot;

   modport master (
      output c1, c2, sync, fnum, block, multi, dt_sign, dt_value,
      input  pg_inc, slot
   );

   modport slave (
      input  c1, c2, sync, fnum, block, multi, dt_sign, dt_value,
      output pg_inc, slot
   );
endinterface

// File: rtl/ym3438_pg_detune_apply.sv
// Applies detune to the per-slot base phase increment and scales it by MULTI (3-slot pipeline).
// Build option: define YM3438_PG_DT_CLAMP_EN to saturate the detune add/sub instead of wrapping.
module ym3438_pg_detune_apply #(
   parameter int SLOTS     = 24,
   parameter int INC_WIDTH = 20
) (
   input  logic                    MCLK,
   input  logic                    IC,
   ym3438_pg_detune_apply_if.slave bus
);

   // Two-phase pipeline: *_m are c1 masters, *_s are c2 slaves.
   logic [16:0] base_m, base_s;
   logic [3:0]  multi0_m, multi0_s;
   logic [16:0] det_m, det_s;
   logic [3:0]  multi1_m, multi1_s;
   logic [INC_WIDTH-1:0] inc_m;
   logic        sync_m;

   logic [17:0] base_full;
   logic [16:0] base_next;
   logic [16:0] det_next;
   logic [20:0] prod;
   logic [20:0] inc_sel;
`ifdef YM3438_PG_DT_CLAMP_EN
   logic [17:0] sum_ext;
   logic [17:0] diff_ext;
`endif

   always_comb begin
      base_full = {7'b0, bus.fnum} << bus.block;
      base_next = 17'(base_full >> 1);
`ifdef YM3438_PG_DT_CLAMP_EN
      sum_ext  = {1'b0, base_s} + {13'b0, bus.dt_value};
      diff_ext = {1'b0, base_s} - {13'b0, bus.dt_value};
      if (bus.dt_sign)
         det_next = diff_ext[17] ? 17'h00000 : diff_ext[16:0];
      else
         det_next = sum_ext[17] ? 17'h1FFFF : sum_ext[16:0];
`else
      det_next = bus.dt_sign ? (base_s - {12'b0, bus.dt_value})
                             : (base_s + {12'b0, bus.dt_value});
`endif
      prod    = {4'b0, det_s} * {17'b0, multi1_s};
      inc_sel = (multi1_s == 4'd0) ? {5'b0, det_s[16:1]} : prod;
   end

   always_ff @(posedge MCLK) begin
      if (!IC) begin
         base_m     <= '0;
         base_s     <= '0;
         multi0_m   <= '0;
         multi0_s   <= '0;
         det_m      <= '0;
         det_s      <= '0;
         multi1_m   <= '0;
         multi1_s   <= '0;
         inc_m      <= '0;
         sync_m     <= 1'b0;
         bus.pg_inc <= '0;
         bus.slot   <= '0;
      end else if (bus.c1) begin
         base_m   <= base_next;
         multi0_m <= bus.multi;
         det_m    <= det_next;
         multi1_m <= multi0_s;
         inc_m    <= INC_WIDTH'(inc_sel);
         // Compare against 1 so an unknown sync is treated as "no sync".
         sync_m   <= (bus.sync === 1'b1);
      end else if (bus.c2) begin
         base_s     <= base_m;
         multi0_s   <= multi0_m;
         det_s      <= det_m;
         multi1_s   <= multi1_m;
         bus.pg_inc <= inc_m;
         // Output tag trails the input slot by the pipeline depth.
         if (sync_m)
            bus.slot <= 5'd3;
         else if (bus.slot == 5'(SLOTS - 1))
            bus.slot <= 5'd0;
         else
            bus.slot <= bus.slot + 5'd1;
      end
   end

endmodule

// File: tb/tb_ym3438_pg_detune_apply.sv
// Scoreboard bench for ym3438_pg_detune_apply: directed and random slot streams vs. an arithmetic model.
module tb_ym3438_pg_detune_apply;

   typedef struct {
      logic [19:0] inc;
      logic [4:0]  slot;
   } exp_t;

   typedef struct {
      int f;
      int b;
      int m;
   } op_t;

   logic mclk;
   logic ic;
   ym3438_pg_detune_apply_if #(.INC_WIDTH(20)) bus ();

   ym3438_pg_detune_apply #(.SLOTS(24), .INC_WIDTH(20)) dut (
      .MCLK (mclk),
      .IC   (ic),
      .bus  (bus)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Model history: operands of the previous two slots and the detune of the previous slot.
   op_t hist1, hist2;
   int  dt_s1, dt_v1;
   int  slot_model;
   int  phase;

   function automatic int model_inc(input op_t op, input int ds, input int dv);
      int base, det, inc;
      base = (op.f * (1 << op.b)) / 2;
      det  = (ds != 0) ? base - dv : base + dv;
`ifdef YM3438_PG_DT_CLAMP_EN
      if (det < 0) det = 0;
      if (det > 131071) det = 131071;
`else
      det = ((det % 131072) + 131072) % 131072;
`endif
      inc = (op.m == 0) ? det / 2 : det * op.m;
      return inc % (1 << 20);
   endfunction

   task automatic model_reset();
      hist1      = '{0, 0, 0};
      hist2      = '{0, 0, 0};
      dt_s1      = 0;
      dt_v1      = 0;
      slot_model = 0;
   endtask

   task automatic step(input int f, input int b, input int m, input bit s,
                       input int ds, input int dv);
      exp_t e;
      op_t  cur;
      @(negedge mclk);
      bus.c1       = 1'b1;
      bus.c2       = 1'b0;
      bus.fnum     = 11'(f);
      bus.block    = 3'(b);
      bus.multi    = 4'(m);
      bus.sync     = s;
      bus.dt_sign  = 1'(ds);
      bus.dt_value = 5'(dv);
      e.inc      = 20'(model_inc(hist2, dt_s1, dt_v1));
      slot_model = s ? 3 : (slot_model + 1) % 24;
      e.slot     = 5'(slot_model);
      exp_q.push_back(e);
      cur   = '{f, b, m};
      hist2 = hist1;
      hist1 = cur;
      dt_s1 = ds;
      dt_v1 = dv;
      @(negedge mclk);
      bus.c1 = 1'b0;
      bus.c2 = 1'b1;
   endtask

   task automatic idle();
      @(negedge mclk);
      bus.c1   = 1'b0;
      bus.c2   = 1'b0;
      bus.sync = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      checks++;
      if (bus.pg_inc !== 20'h0) begin
         errors++;
         $display("FAIL %s_pg_inc actual=%05h required=00000", tag, bus.pg_inc);
      end
      checks++;
      if (bus.slot !== 5'd0) begin
         errors++;
         $display("FAIL %s_slot actual=%0d required=0", tag, bus.slot);
      end
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge mclk);
      ic     = 1'b0;
      bus.c1 = 1'b0;
      bus.c2 = 1'b0;
      @(negedge mclk);
      check_reset(tag);
      model_reset();
      // c2 while IC is low must not move anything.
      bus.c2 = 1'b1;
      @(negedge mclk);
      check_reset({tag, "_hold"});
      bus.c2 = 1'b0;
      ic     = 1'b1;
   endtask

   // Monitor: every c2 outside reset presents one result.
   always @(posedge mclk) begin
      if (ic && bus.c2) begin
         exp_t e;
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow actual=%05h/%0d required=queued entry",
                     bus.pg_inc, bus.slot);
         end else begin
            e = exp_q.pop_front();
            if (bus.pg_inc !== e.inc) begin
               errors++;
               $display("FAIL pg_inc actual=%05h required=%05h (tag %0d)",
                        bus.pg_inc, e.inc, e.slot);
            end
            checks++;
            if (bus.slot !== e.slot) begin
               errors++;
               $display("FAIL slot actual=%0d required=%0d", bus.slot, e.slot);
            end
         end
      end
   end

   // Directed operands; each entry's detune is presented one slot after its operands.
   int d_f[6]  = '{'h200, 'h200, 'h200, 'h000, 'h7FF, 'h7FF};
   int d_b[6]  = '{4, 4, 4, 0, 7, 7};
   int d_m[6]  = '{1, 1, 1, 1, 15, 0};
   int d_ds[6] = '{0, 0, 1, 1, 0, 0};
   int d_dv[6] = '{0, 5, 5, 3, 0, 0};

   initial begin
      ic           = 1'b0;
      bus.c1       = 1'b0;
      bus.c2       = 1'b0;
      bus.sync     = 1'b0;
      bus.fnum     = '0;
      bus.block    = '0;
      bus.multi    = '0;
      bus.dt_sign  = 1'b0;
      bus.dt_value = '0;
      model_reset();
      repeat (3) @(negedge mclk);
      check_reset("por");
      ic = 1'b1;

      for (int i = 0; i < 6; i++)
         step(d_f[i], d_b[i], d_m[i], i == 0,
              (i > 0) ? d_ds[i-1] : 0, (i > 0) ? d_dv[i-1] : 0);
      step(0, 0, 0, 1'b0, d_ds[5], d_dv[5]);
      step(0, 0, 0, 1'b0, 0, 0);
      step(0, 0, 0, 1'b0, 0, 0);
      idle();

      phase = int'($urandom_range(0, 23));
      for (int i = 0; i < 72; i++) begin
         step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), (phase % 24) == 0,
              int'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
         phase++;
      end

      pulse_reset("midstream");

      phase = 5;
      for (int i = 0; i < 40; i++) begin
         step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), (phase % 24) == 0,
              int'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
         phase++;
      end
      idle();
      repeat (4) @(negedge mclk);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
